// File: rtl/ps2_device_emulator.sv
// ps2_device_emulator: PS/2 device end (keyboard/mouse emulation) that clocks device-to-host and host-to-device frames
// Optional feature macro PS2_DEV_AUTO_ACK_EN: answer each error-free host command with 8'hFA ahead of user bytes.
module ps2_device_emulator #(
  parameter int CLK_HALF    = 2000,
  parameter int INHIBIT_CYC = 5000,
  parameter int IDLE_CYC    = 2500
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       busy,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);
  localparam int MAXP = (CLK_HALF > INHIBIT_CYC) ? ((CLK_HALF > IDLE_CYC) ? CLK_HALF : IDLE_CYC)
                                                 : ((INHIBIT_CYC > IDLE_CYC) ? INHIBIT_CYC : IDLE_CYC);
  localparam int W = $clog2(MAXP + 1);
  localparam logic [W-1:0] HALF_END = W'(CLK_HALF - 1);
  localparam logic [W-1:0] IDLE_END = W'(IDLE_CYC - 1);
  localparam logic [W-1:0] INH_MIN  = W'(INHIBIT_CYC);
  localparam logic [W-1:0] SYNC_LAG = W'(2);
`ifdef PS2_DEV_AUTO_ACK_EN
  localparam bit AUTO_ACK = 1'b1;
`else
  localparam bit AUTO_ACK = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, TX_WAIT, TX_BIT, RX_BIT, RX_ACK, INHIBIT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic low_q, low_d;
  logic [10:0] sh_q, sh_d;
  logic pend_q, pend_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic ack_q, ack_d;
  logic clk_oe_q, clk_oe_d;
  logic dat_oe_q, dat_oe_d;
  logic [1:0] ck_q, ck_d;
  logic [1:0] dt_q, dt_d;
  logic tx_ready_q, tx_ready_d;
  logic tx_done_q, tx_done_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d;
  logic rx_error_q, rx_error_d;
  logic busy_q, busy_d;
  logic ck, dt, settled, half_end;
  logic [7:0] tx_byte;
  logic [10:0] tx_frame;
  assign ck = ck_q[1];
  assign dt = dt_q[1];
  assign settled = cnt_q == SYNC_LAG;
  assign half_end = cnt_q == HALF_END;
  assign tx_byte = ack_q ? 8'hFA : pend_data_q;
  assign tx_frame = {1'b1, ~^tx_byte, tx_byte, 1'b0};
  assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;
  assign tx_ready = tx_ready_q;
  assign tx_done = tx_done_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_error = rx_error_q;
  assign busy = busy_q;
  // Next state: pin sync, byte capture, link FSM; IDLE waits out the sync lag so a just-released CLK is not read as inhibit
  always_comb begin
    ck_d = {ck_q[0], PS2_CLK};
    dt_d = {dt_q[0], PS2_DAT};
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    low_d = low_q;
    sh_d = sh_q;
    pend_d = pend_q;
    pend_data_d = pend_data_q;
    ack_d = ack_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    tx_done_d = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d = rx_data_q;
    rx_error_d = rx_error_q;
    if (tx_valid && tx_ready_q) begin
      pend_d = 1'b1;
      pend_data_d = tx_data;
    end
    case (state_q)
      IDLE: begin
        cnt_d = settled ? cnt_q : cnt_q + 1'b1;
        state_d = !settled ? IDLE : !ck ? INHIBIT : (pend_q || ack_q) ? TX_WAIT : IDLE;
        if (state_d != IDLE) cnt_d = '0;
      end
      TX_WAIT: begin
        cnt_d = (ck && dt) ? cnt_q + 1'b1 : '0;
        if (!ck) state_d = INHIBIT;
        else if (dt && cnt_q == IDLE_END) begin
          state_d = TX_BIT;
          cnt_d = '0;
          bit_d = '0;
          low_d = 1'b0;
          sh_d = tx_frame;
          dat_oe_d = !tx_frame[0];
        end
      end
      INHIBIT: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        low_d = 1'b0;
        bit_d = '0;
        cnt_d = ck ? '0 : (cnt_q == INH_MIN) ? cnt_q : cnt_q + 1'b1;
        if (ck) state_d = (!dt && cnt_q == INH_MIN) ? RX_BIT : IDLE;
      end
      default: begin
        cnt_d = half_end ? '0 : cnt_q + 1'b1;
        if (!low_q && !ck && cnt_q >= SYNC_LAG) begin
          state_d = INHIBIT;
          cnt_d = '0;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
        end else if (half_end && !low_q) begin
          low_d = 1'b1;
          clk_oe_d = 1'b1;
        end else if (half_end) begin
          low_d = 1'b0;
          clk_oe_d = 1'b0;
          bit_d = bit_q + 1'b1;
          if (state_q == TX_BIT) begin
            sh_d = sh_q >> 1;
            dat_oe_d = !sh_q[1];
            if (bit_q == 4'd10) begin
              state_d = IDLE;
              dat_oe_d = 1'b0;
              ack_d = 1'b0;
              tx_done_d = !ack_q;
              if (!ack_q) pend_d = 1'b0;
            end
          end else if (state_q == RX_BIT) begin
            sh_d = {dt, sh_q[10:1]};
            if (bit_q == 4'd9) begin
              state_d = RX_ACK;
              dat_oe_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
            dat_oe_d = 1'b0;
            rx_valid_d = 1'b1;
            rx_data_d = sh_q[8:1];
            rx_error_d = !(^sh_q[9:1]) || !sh_q[10];
            ack_d = ack_q || (AUTO_ACK && !rx_error_d);
          end
        end
      end
    endcase
    tx_ready_d = !pend_d && !ack_d;
    busy_d = state_d != IDLE;
  end
  // State and registered outputs; reset releases both pins and clears any partial frame
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      low_q <= 1'b0;
      sh_q <= '0;
      pend_q <= 1'b0;
      pend_data_q <= 8'h00;
      ack_q <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      ck_q <= 2'b11;
      dt_q <= 2'b11;
      tx_ready_q <= 1'b0;
      tx_done_q <= 1'b0;
      rx_data_q <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      low_q <= low_d;
      sh_q <= sh_d;
      pend_q <= pend_d;
      pend_data_q <= pend_data_d;
      ack_q <= ack_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      ck_q <= ck_d;
      dt_q <= dt_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q <= tx_done_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_ps2_device_emulator.sv
// tb_ps2_device_emulator: directed host-side model driving the PS/2 device emulator over pulled-up open-drain pins
module tb_ps2_device_emulator;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, tx_done, rx_valid, rx_error, busy;
  logic [7:0] rx_data;
  logic h_clk = 1'b1;
  logic h_dat = 1'b1;
  wire PS2_CLK, PS2_DAT;
  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_rxv = 0;
  typedef struct { logic [7:0] d; logic [10:0] f; } txv_t;
  typedef struct { logic [7:0] b; logic par; logic stp; logic err; } rxv_t;
  txv_t txv [6];
  rxv_t rxv [6];
  pullup (PS2_CLK);
  pullup (PS2_DAT);
  assign PS2_CLK = h_clk ? 1'bz : 1'b0;
  assign PS2_DAT = h_dat ? 1'bz : 1'b0;
  ps2_device_emulator #(.CLK_HALF(20), .INHIBIT_CYC(50), .IDLE_CYC(30)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_error(rx_error), .busy(busy), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT));
  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) begin
    #1;
    if (tx_done === 1'b1) n_done++;
    if (rx_valid === 1'b1) n_rxv++;
  end
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask
  task automatic wait_ready();
    int i = 0;
    while (i < 500 && tx_ready !== 1'b1) begin
      @(negedge CLOCK_50);
      i++;
    end
    chk("tx_ready_wait", tx_ready, 1);
  endtask
  task automatic host_recv(output logic [10:0] f, output bit ok);
    logic prev;
    int n = 0;
    f = '0;
    prev = PS2_CLK;
    for (int i = 0; i < 3000 && n < 11; i++) begin
      @(negedge CLOCK_50);
      if (prev === 1'b1 && PS2_CLK === 1'b0) begin
        f[n] = (PS2_DAT === 1'b1);
        n++;
      end
      prev = PS2_CLK;
    end
    ok = (n == 11);
  endtask
  task automatic host_send(input logic [7:0] b, input logic par, input logic stp, input bit offer,
                           input logic [7:0] ob, output bit acked, output bit ok);
    logic [9:0] bits;
    logic prev;
    int n = 0;
    bits = {stp, par, b};
    acked = 1'b0;
    h_clk = 1'b0;
    cyc(10);
    if (offer) begin
      tx_data = ob;
      tx_valid = 1'b1;
      cyc(1);
      tx_valid = 1'b0;
    end
    h_dat = 1'b0;
    cyc(60);
    h_clk = 1'b1;
    prev = 1'b1;
    for (int i = 0; i < 3000 && n < 11; i++) begin
      @(negedge CLOCK_50);
      if (prev === 1'b1 && PS2_CLK === 1'b0) begin
        if (n < 10) h_dat = bits[n];
        else begin
          acked = (PS2_DAT === 1'b0);
          h_dat = 1'b1;
        end
        n++;
      end
      prev = PS2_CLK;
    end
    h_dat = 1'b1;
    ok = (n == 11);
  endtask
  initial begin
    logic [10:0] f;
    bit ok, acked;
    logic prev;
    int n, d0, v0;
    txv[0] = '{8'hAA, 11'b1_1_10101010_0};
    txv[1] = '{8'h12, 11'b1_1_00010010_0};
    txv[2] = '{8'h01, 11'b1_0_00000001_0};
    txv[3] = '{8'h80, 11'b1_0_10000000_0};
    txv[4] = '{8'hF4, 11'b1_0_11110100_0};
    txv[5] = '{8'h00, 11'b1_1_00000000_0};
    rxv[0] = '{8'hF4, 1'b0, 1'b1, 1'b0};
    rxv[1] = '{8'hF4, 1'b1, 1'b1, 1'b1};
    rxv[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    rxv[3] = '{8'h01, 1'b0, 1'b1, 1'b0};
    rxv[4] = '{8'h55, 1'b0, 1'b1, 1'b1};
    rxv[5] = '{8'h3C, 1'b1, 1'b0, 1'b1};
    cyc(3);
    chk("rst_clk_pin", PS2_CLK, 1);
    chk("rst_dat_pin", PS2_DAT, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_error", rx_error, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    cyc(2);
    chk("post_rst_tx_ready", tx_ready, 1);
    for (int k = 0; k < 6; k++) begin
      wait_ready();
      d0 = n_done;
      tx_data = txv[k].d;
      tx_valid = 1'b1;
      cyc(1);
      if (k == 0) begin
        tx_data = 8'h77;
        cyc(5);
      end
      tx_valid = 1'b0;
      chk("tx_ready_low", tx_ready, 0);
      host_recv(f, ok);
      chk("tx_frame_timeout", ok, 1);
      chk("tx_frame", f, txv[k].f);
      cyc(40);
      chk("tx_done_once", n_done - d0, 1);
      chk("tx_ready_back", tx_ready, 1);
    end
    cyc(100);
    chk("no_spurious_tx", busy, 0);
    wait_ready();
    d0 = n_done;
    tx_data = 8'h12;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    n = 0;
    ok = 1'b0;
    prev = PS2_CLK;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge CLOCK_50);
      if (prev === 1'b1 && PS2_CLK === 1'b0) n++;
      if (n == 4 && prev === 1'b0 && PS2_CLK === 1'b1) ok = 1'b1;
      prev = PS2_CLK;
    end
    chk("abort_reach_bit4", ok, 1);
    cyc(5);
    chk("abort_dat_driven", PS2_DAT, 0);
    h_clk = 1'b0;
    cyc(3);
    chk("abort_dat_released", PS2_DAT, 1);
    chk("abort_busy", busy, 1);
    cyc(57);
    h_clk = 1'b1;
    chk("abort_no_done", n_done - d0, 0);
    host_recv(f, ok);
    chk("resend_timeout", ok, 1);
    chk("resend_frame", f, 11'b1_1_00010010_0);
    cyc(40);
    chk("resend_done_once", n_done - d0, 1);
    for (int k = 0; k < 6; k++) begin
      v0 = n_rxv;
      d0 = n_done;
      host_send(rxv[k].b, rxv[k].par, rxv[k].stp, 1'b0, 8'h00, acked, ok);
      chk("rx_timeout", ok, 1);
      if (rxv[k].stp) chk("rx_ack_bit", acked, 1);
      cyc(40);
      chk("rx_valid_once", n_rxv - v0, 1);
      chk("rx_data", rx_data, rxv[k].b);
      chk("rx_error", rx_error, rxv[k].err);
`ifdef PS2_DEV_AUTO_ACK_EN
      if (!rxv[k].err) begin
        host_recv(f, ok);
        chk("auto_ack_frame", f, 11'b1_1_11111010_0);
        cyc(40);
      end
`endif
      chk("rx_no_tx_done", n_done - d0, 0);
    end
    cyc(100);
    chk("rx_idle_after", busy, 0);
    v0 = n_rxv;
    d0 = n_done;
    host_send(8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, acked, ok);
    chk("rts_pend_timeout", ok, 1);
    chk("rts_pend_ack_bit", acked, 1);
    cyc(40);
    chk("rts_pend_rx_valid", n_rxv - v0, 1);
    chk("rts_pend_rx_data", rx_data, 8'hFF);
    chk("rts_pend_rx_error", rx_error, 0);
`ifdef PS2_DEV_AUTO_ACK_EN
    host_recv(f, ok);
    chk("rts_pend_fa_frame", f, 11'b1_1_11111010_0);
`endif
    host_recv(f, ok);
    chk("rts_pend_user_timeout", ok, 1);
    chk("rts_pend_user_frame", f, 11'b1_1_00000000_0);
    cyc(40);
    chk("rts_pend_done_once", n_done - d0, 1);
    chk("rts_pend_tx_ready", tx_ready, 1);
    v0 = n_rxv;
    h_clk = 1'b0;
    cyc(10);
    h_dat = 1'b0;
    cyc(60);
    h_clk = 1'b1;
    n = 0;
    prev = 1'b1;
    for (int i = 0; i < 3000 && n < 6; i++) begin
      @(negedge CLOCK_50);
      if (prev === 1'b1 && PS2_CLK === 1'b0) begin
        h_dat = n[0] ? 1'b0 : (n != 4);
        n++;
      end
      prev = PS2_CLK;
    end
    chk("rst_rx_reach_bit5", n, 6);
    cyc(5);
    chk("rst_rx_clk_low", PS2_CLK, 0);
    h_dat = 1'b1;
    reset = 1'b1;
    cyc(1);
    chk("rst_rx_clk_released", PS2_CLK, 1);
    chk("rst_rx_dat_released", PS2_DAT, 1);
    cyc(2);
    reset = 1'b0;
    cyc(100);
    chk("rst_rx_no_valid", n_rxv - v0, 0);
    chk("rst_rx_tx_ready", tx_ready, 1);
    chk("rst_rx_busy", busy, 0);
    chk("rst_rx_data_clr", rx_data, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
